// File: rtl/axis_burst_pkg.sv
// rtl/axis_burst_pkg.sv - shared state type and constants for the AXIS burst packer
package axis_burst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    SETTLE = 2'd2
  } state_e;

  // Cycles to wait after the last read so the FIFO's registered level is current again.
  localparam int SETTLE_CYCLES = 2;

  // Entries needed to absorb the FIFO's one-cycle read latency under backpressure.
  localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axis_skid_buffer.sv
// rtl/axis_skid_buffer.sv - 2-entry registered skid holding {data, user, last} in FIFO order
module axis_skid_buffer
  import axis_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [USER_WIDTH-1:0] push_user_i,
  input  logic                  push_last_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [USER_WIDTH-1:0] head_user_o,
  output logic                  head_last_o,
  output logic [1:0]            occ_o
);

  localparam int W = DATA_WIDTH + USER_WIDTH + 1;

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] push_word;

  assign push_word = {push_last_i, push_user_i, push_data_i};

  // Entry 0 is always the head; a pop shifts entry 1 forward, so the head only
  // changes on a pop or on a push into an empty buffer.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    case ({push_i, pop_i})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = push_word;
        else               ent1_d = push_word;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          ent0_d = push_word;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_word;
        end
      end
      default: ;
    endcase
  end

  // Storage and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      occ_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      occ_q  <= occ_d;
    end
  end

  assign {head_last_o, head_user_o, head_data_o} = ent0_q;
  assign occ_o = occ_q;

  // A returning beat must always find a free slot; the read throttle guarantees it.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && !pop_i && (occ_q == 2'(SKID_DEPTH))));

endmodule

// File: rtl/axis_burst_packer.sv
// rtl/axis_burst_packer.sv - pulls fixed bursts from a sync AXIS FIFO and emits tlast-framed packets; optional BURST_PACKER_TIMEOUT_EN partial flush
module axis_burst_packer
  import axis_burst_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int FIFO_LEN   = 8,
  parameter int BURST_LEN  = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [DATA_WIDTH-1:0]       s_fifo_tdata,
  input  logic [USER_WIDTH-1:0]       s_fifo_tuser,
  input  logic                        s_fifo_tvalid,
  input  logic [$clog2(FIFO_LEN)-1:0] s_fifo_tlevel,
  input  logic                        s_fifo_tempty,
  output logic                        s_fifo_tready,
  output logic [DATA_WIDTH-1:0]       m_axis_out_tdata,
  output logic [USER_WIDTH-1:0]       m_axis_out_tuser,
  output logic                        m_axis_out_tvalid,
  output logic                        m_axis_out_tlast,
  input  logic                        m_axis_out_tready,
  output logic [15:0]                 burst_count_o,
  output logic                        partial_flush_o
);

  localparam int LVL_W = $clog2(FIFO_LEN);
  localparam int EFF_W = LVL_W + 1;
  localparam logic [EFF_W-1:0] BURST_LEN_E = EFF_W'(BURST_LEN);
  localparam logic [EFF_W-1:0] FIFO_LEN_E  = EFF_W'(FIFO_LEN);

  state_e           state_q, state_d;
  logic [EFF_W-1:0] beats_left_q, beats_left_d;
  logic [1:0]       settle_q, settle_d;
  logic             inflight_q, inflight_last_q;
  logic [15:0]      burst_count_q, burst_count_d;
  logic [EFF_W-1:0] eff;
  logic [1:0]       skid_occ;
  logic [2:0]       fill;
  logic             room, out_hs, skid_push;
  logic             issue, issue_last, timeout_hit;

  // The FIFO level wraps to 0 when full, so full is recovered from the empty flag.
  assign eff = s_fifo_tempty ? '0 :
               (s_fifo_tlevel == '0) ? FIFO_LEN_E : {1'b0, s_fifo_tlevel};

  assign out_hs = m_axis_out_tvalid && m_axis_out_tready;
  assign fill   = {1'b0, skid_occ} + {2'b00, inflight_q};
  assign room   = (fill <= 3'd1) || ((fill == 3'd2) && out_hs);

  // Burst sequencing: start on a full burst (or timeout), throttle reads on skid room, then settle.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    settle_d     = settle_q;
    issue        = 1'b0;
    case (state_q)
      IDLE: begin
        if (eff >= BURST_LEN_E) begin
          state_d      = BURST;
          beats_left_d = BURST_LEN_E;
        end else if (timeout_hit) begin
          state_d      = BURST;
          beats_left_d = eff;
        end
      end
      BURST: begin
        issue = (beats_left_q != '0) && room;
        if (issue) begin
          beats_left_d = beats_left_q - EFF_W'(1);
          if (beats_left_q == EFF_W'(1)) begin
            state_d  = SETTLE;
            settle_d = '0;
          end
        end
      end
      SETTLE: begin
        settle_d = settle_q + 2'd1;
        if (settle_q == 2'(SETTLE_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign issue_last    = issue && (beats_left_q == EFF_W'(1));
  assign s_fifo_tready = issue;

  // Beats arriving without a matching tracked read (e.g. issued before a reset) are dropped.
  assign skid_push = s_fifo_tvalid && inflight_q;

  // Packet counter advances when a tlast beat leaves.
  always_comb begin
    burst_count_d = burst_count_q;
    if (out_hs && m_axis_out_tlast) burst_count_d = burst_count_q + 16'd1;
  end

  // State, read tracking and packet counter registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q         <= IDLE;
      beats_left_q    <= '0;
      settle_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      burst_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      beats_left_q    <= beats_left_d;
      settle_q        <= settle_d;
      inflight_q      <= issue;
      inflight_last_q <= issue_last;
      burst_count_q   <= burst_count_d;
    end
  end

  assign burst_count_o = burst_count_q;

`ifdef BURST_PACKER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
  logic            partial_q, partial_d;
  logic            idle_partial;

  assign idle_partial = (state_q == IDLE) && (eff != '0) && (eff < BURST_LEN_E);
  assign timeout_hit  = idle_partial && (idle_cnt_q == TO_W'(TIMEOUT - 1));

  // Idle counter runs only while a partial burst waits; partial flag marks a timeout packet.
  always_comb begin
    idle_cnt_d = '0;
    if (idle_partial && !timeout_hit) idle_cnt_d = idle_cnt_q + TO_W'(1);
    partial_d = partial_q;
    if (timeout_hit)     partial_d = 1'b1;
    else if (issue_last) partial_d = 1'b0;
  end

  // Timeout registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idle_cnt_q <= '0;
      partial_q  <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      partial_q  <= partial_d;
    end
  end

  assign partial_flush_o = partial_q && issue_last;
`else
  assign timeout_hit     = 1'b0;
  assign partial_flush_o = 1'b0;
`endif

  axis_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (skid_push),
    .push_data_i (s_fifo_tdata),
    .push_user_i (s_fifo_tuser),
    .push_last_i (inflight_last_q),
    .pop_i       (out_hs),
    .head_data_o (m_axis_out_tdata),
    .head_user_o (m_axis_out_tuser),
    .head_last_o (m_axis_out_tlast),
    .occ_o       (skid_occ)
  );

  assign m_axis_out_tvalid = (skid_occ != 2'd0);

  a_params: assert property (@(posedge clk_i)
    (BURST_LEN >= 1) && (BURST_LEN <= FIFO_LEN) && (TIMEOUT >= 1));

endmodule
